// File: rtl/bmp_stream_if.sv
// Byte-in / pixel-out stream bundle for the BMP parser.
// The slave side is the parser; the master side feeds file bytes and sinks pixels.
interface bmp_stream_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic        out_eol;
  logic        out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_x, out_y, out_eol, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_x, out_y, out_eol, out_last
  );
endinterface

// File: rtl/bmp_stream_parser.sv
// Streaming parser for uncompressed 24-bit BMP files.
// Bytes arrive in file order; the 54-byte header is decoded and validated,
// the gap up to the pixel array is skipped, and pixels are emitted one per
// handshake as {R,G,B} with column/row coordinates. Row padding is dropped.
module bmp_stream_parser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  bmp_stream_if.slave bus,
  output logic        hdr_valid,
  output logic [31:0] file_size,
  output logic [31:0] data_offset,
  output logic [31:0] bmp_width,
  output logic [31:0] bmp_height,
  output logic        done,
  output logic [1:0]  err
);

  typedef enum logic [2:0] {ST_HDR, ST_SKIP, ST_PIX, ST_PAD, ST_DONE, ST_ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] bcnt_q;
  logic [15:0] sig_q, bpp_q;
  logic [31:0] fsize_q, doff_q, width_q, height_q;
  logic        hdr_valid_q, done_q;
  logic [1:0]  err_q;
  logic [1:0]  ph_q, pad_cnt_q;
  logic [7:0]  b_q, g_q;
  logic [15:0] x_q;
  logic [31:0] y_q;
  logic        ov_q;
  logic [23:0] od_q;
  logic [15:0] ox_q, oy_q;
  logic        oeol_q, olast_q;

  logic        in_ready_w, accept, hdr_end, skip_end, r_accept;
  logic        row_end, last_row, pad_end, out_fire;
  logic [1:0]  pad_len, hdr_err;

  // Error code for a fully captured header; signature beats bpp beats geometry.
  function automatic logic [1:0] header_check(input logic [15:0] sig, input logic [15:0] bpp,
                                               input logic [31:0] w, input logic [31:0] h,
                                               input logic [31:0] off);
    if (sig != 16'h4D42) return 2'd1;
    if (bpp != 16'd24) return 2'd2;
    if (w == 32'd0 || w > 32'd65535 || h == 32'd0 || h[31] || off < 32'd54) return 2'd3;
    return 2'd0;
  endfunction

  // The R byte completes a pixel, so it may only enter when the output slot frees.
  assign in_ready_w = !restart &&
                      !(state_q == ST_PIX && ph_q == 2'd2 && ov_q && !bus.out_ready);
  assign accept     = bus.in_valid && in_ready_w;
  assign hdr_end    = (state_q == ST_HDR) && accept && (bcnt_q == 32'd53);
  assign skip_end   = (state_q == ST_SKIP) && accept && (bcnt_q == doff_q - 32'd1);
  assign r_accept   = (state_q == ST_PIX) && accept && (ph_q == 2'd2);
  assign pad_len    = width_q[1:0];
  assign row_end    = ({16'd0, x_q} == width_q - 32'd1);
  assign last_row   = (y_q == height_q - 32'd1);
  assign pad_end    = (state_q == ST_PAD) && accept && (pad_cnt_q == pad_len - 2'd1);
  assign out_fire   = ov_q && bus.out_ready;
  assign hdr_err    = header_check(sig_q, bpp_q, width_q, height_q, doff_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HDR;
    else        state_q <= state_d;
  end

  // Next-state logic; y_q has already advanced past the row when PAD finishes.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = ST_HDR;
    end else begin
      case (state_q)
        ST_HDR: begin
          if (hdr_end) begin
            if (hdr_err != 2'd0)        state_d = ST_ERR;
            else if (doff_q == 32'd54)  state_d = ST_PIX;
            else                        state_d = ST_SKIP;
          end
        end
        ST_SKIP: if (skip_end) state_d = ST_PIX;
        ST_PIX: begin
          if (r_accept && row_end) begin
            if (pad_len != 2'd0) state_d = ST_PAD;
            else if (last_row)   state_d = ST_DONE;
          end
        end
        ST_PAD: if (pad_end) state_d = (y_q == height_q) ? ST_DONE : ST_PIX;
        default: state_d = state_q;
      endcase
    end
  end

  // Byte counter, little-endian header field capture and header verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q      <= '0;
      sig_q       <= '0;
      bpp_q       <= '0;
      fsize_q     <= '0;
      doff_q      <= '0;
      width_q     <= '0;
      height_q    <= '0;
      hdr_valid_q <= 1'b0;
      err_q       <= 2'd0;
    end else if (restart) begin
      bcnt_q      <= '0;
      sig_q       <= '0;
      bpp_q       <= '0;
      fsize_q     <= '0;
      doff_q      <= '0;
      width_q     <= '0;
      height_q    <= '0;
      hdr_valid_q <= 1'b0;
      err_q       <= 2'd0;
    end else begin
      if (accept) bcnt_q <= bcnt_q + 32'd1;
      if (state_q == ST_HDR && accept) begin
        if (bcnt_q < 32'd2)                      sig_q    <= {bus.in_data, sig_q[15:8]};
        if (bcnt_q >= 32'd2  && bcnt_q <= 32'd5)  fsize_q  <= {bus.in_data, fsize_q[31:8]};
        if (bcnt_q >= 32'd10 && bcnt_q <= 32'd13) doff_q   <= {bus.in_data, doff_q[31:8]};
        if (bcnt_q >= 32'd18 && bcnt_q <= 32'd21) width_q  <= {bus.in_data, width_q[31:8]};
        if (bcnt_q >= 32'd22 && bcnt_q <= 32'd25) height_q <= {bus.in_data, height_q[31:8]};
        if (bcnt_q >= 32'd28 && bcnt_q <= 32'd29) bpp_q    <= {bus.in_data, bpp_q[15:8]};
      end
      if (hdr_end) begin
        if (hdr_err != 2'd0) err_q       <= hdr_err;
        else                 hdr_valid_q <= 1'b1;
      end
    end
  end

  // Pixel assembly, coordinate tracking, padding count and the output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q      <= 2'd0;
      pad_cnt_q <= 2'd0;
      b_q       <= '0;
      g_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      ov_q      <= 1'b0;
      od_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      oeol_q    <= 1'b0;
      olast_q   <= 1'b0;
      done_q    <= 1'b0;
    end else if (restart) begin
      ph_q      <= 2'd0;
      pad_cnt_q <= 2'd0;
      x_q       <= '0;
      y_q       <= '0;
      ov_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (state_q == ST_PIX && accept) begin
        if (ph_q == 2'd0) b_q <= bus.in_data;
        if (ph_q == 2'd1) g_q <= bus.in_data;
        ph_q <= (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
      end
      if (r_accept) begin
        od_q    <= {bus.in_data, g_q, b_q};
        ox_q    <= x_q;
        oy_q    <= y_q[15:0];
        oeol_q  <= row_end;
        olast_q <= row_end && last_row;
        if (row_end) begin
          x_q <= '0;
          y_q <= y_q + 32'd1;
        end else begin
          x_q <= x_q + 16'd1;
        end
      end
      if (state_q == ST_PAD && accept) pad_cnt_q <= pad_end ? 2'd0 : pad_cnt_q + 2'd1;
      // A new pixel overwrites the slot in the same cycle the old one leaves.
      if (r_accept)      ov_q <= 1'b1;
      else if (out_fire) ov_q <= 1'b0;
      if (out_fire && olast_q) done_q <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_x     = ox_q;
  assign bus.out_y     = oy_q;
  assign bus.out_eol   = oeol_q;
  assign bus.out_last  = olast_q;
  assign hdr_valid     = hdr_valid_q;
  assign file_size     = fsize_q;
  assign data_offset   = doff_q;
  assign bmp_width     = width_q;
  assign bmp_height    = height_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_bmp_stream_parser.sv
// Directed bench for bmp_stream_parser: builds small BMP files in memory,
// streams them in and compares the emitted pixels and status against
// hand-computed values.
module tb_bmp_stream_parser;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart;
  logic        hdr_valid, done;
  logic [31:0] file_size, data_offset, bmp_width, bmp_height;
  logic [1:0]  err;

  bmp_stream_if bus ();

  bmp_stream_parser dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (restart),
    .bus         (bus),
    .hdr_valid   (hdr_valid),
    .file_size   (file_size),
    .data_offset (data_offset),
    .bmp_width   (bmp_width),
    .bmp_height  (bmp_height),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  fb [0:255];
  logic [57:0] pq [$];
  int          ov_seen = 0;

  // Record every pixel handshake ({data,x,y,eol,last}) and every cycle out_valid is high.
  always @(negedge clk) begin
    if (bus.out_valid) ov_seen <= ov_seen + 1;
    if (bus.out_valid && bus.out_ready)
      pq.push_back({bus.out_data, bus.out_x, bus.out_y, bus.out_eol, bus.out_last});
  end

  task automatic build(input logic [7:0] s0, input logic [15:0] bpp, input logic [31:0] w,
                       input logic [31:0] h, input logic [31:0] off, input logic [127:0] pv,
                       input int npay);
    logic [31:0] fsz;
    fsz = off + npay;
    for (int k = 0; k < 256; k++) fb[k] = (k < 54) ? 8'h00 : 8'hA5;
    fb[0] = s0; fb[1] = 8'h4D; fb[14] = 8'd40; fb[26] = 8'd1;
    for (int k = 0; k < 4; k++) begin
      fb[2 + k]  = fsz[8*k +: 8];
      fb[10 + k] = off[8*k +: 8];
      fb[18 + k] = w[8*k +: 8];
      fb[22 + k] = h[8*k +: 8];
    end
    fb[28] = bpp[7:0]; fb[29] = bpp[15:8];
    for (int k = 0; k < npay; k++) fb[off + k] = pv[8*(15 - k) +: 8];
  endtask

  // Entered and left at posedge+1; a byte counts as taken when in_ready was high before the edge.
  task automatic stream(input int first, input int cnt);
    int   i, guard;
    logic acc;
    i = first; guard = 0;
    while (i < first + cnt) begin
      bus.in_valid = 1'b1;
      bus.in_data  = fb[i];
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
      if (guard > 2000) begin
        total++; bad++;
        $display("FAIL stream_timeout: got %0d bytes taken, want %0d", i - first, cnt);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_restart();
    bus.in_valid = 1'b0;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; restart = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    total++; if ({hdr_valid, done, err} !== 4'b0000) begin bad++; $display("FAIL rst_status: got %b want 0000", {hdr_valid, done, err}); end
    total++; if ({file_size, data_offset, bmp_width, bmp_height} !== 128'd0) begin bad++; $display("FAIL rst_fields: got %h want 0", {file_size, data_offset, bmp_width, bmp_height}); end
  endtask

  task automatic test_frame_2x2(input int off);
    logic [127:0] pv;
    logic [57:0]  exp_px [4];
    int           st;
    exp_px[0] = {24'h030201, 16'd0, 16'd0, 1'b0, 1'b0};
    exp_px[1] = {24'h060504, 16'd1, 16'd0, 1'b1, 1'b0};
    exp_px[2] = {24'h090807, 16'd0, 16'd1, 1'b0, 1'b0};
    exp_px[3] = {24'h0C0B0A, 16'd1, 16'd1, 1'b1, 1'b1};
    do_restart();
    bus.out_ready = 1'b1;
    pv = 128'h01020304050600000708090A0B0C0000;
    build(8'h42, 16'd24, 32'd2, 32'd2, off, pv, 16);
    st = pq.size();
    stream(0, off + 16);
    settle(4);
    total++; if (pq.size() - st != 4) begin bad++; $display("FAIL f2x2_count off=%0d: got %0d want 4", off, pq.size() - st); end
    for (int k = 0; k < 4; k++) begin
      if (st + k < pq.size()) begin
        total++;
        if (pq[st + k] !== exp_px[k]) begin bad++; $display("FAIL f2x2_pix%0d off=%0d: got %h want %h", k, off, pq[st + k], exp_px[k]); end
      end
    end
    total++; if ({hdr_valid, done, err} !== 4'b1100) begin bad++; $display("FAIL f2x2_status off=%0d: got %b want 1100", off, {hdr_valid, done, err}); end
    total++; if (bmp_width !== 32'd2 || bmp_height !== 32'd2) begin bad++; $display("FAIL f2x2_geom: got %0d x %0d want 2 x 2", bmp_width, bmp_height); end
    total++; if (data_offset !== off || file_size !== off + 16) begin bad++; $display("FAIL f2x2_fields: got off=%0d size=%0d want %0d %0d", data_offset, file_size, off, off + 16); end
  endtask

  task automatic test_bad_signature();
    int ov0;
    do_restart();
    build(8'h41, 16'd24, 32'd2, 32'd2, 32'd54, 128'd0, 0);
    ov0 = ov_seen;
    stream(0, 53);
    total++; if (err !== 2'd0) begin bad++; $display("FAIL sig_err_early: got %0d want 0", err); end
    stream(53, 1);
    total++; if (err !== 2'd1) begin bad++; $display("FAIL sig_err: got %0d want 1", err); end
    stream(54, 8);
    total++; if (err !== 2'd1 || hdr_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL sig_hold: got err=%0d hv=%b done=%b want 1 0 0", err, hdr_valid, done); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL sig_in_ready: got %b want 1", bus.in_ready); end
    total++; if (ov_seen != ov0) begin bad++; $display("FAIL sig_out_valid: got %0d valid cycles want 0", ov_seen - ov0); end
  endtask

  task automatic test_bad_header();
    logic [15:0] bpps [4];
    logic [31:0] ws [4], hs [4], offs [4];
    logic [1:0]  exps [4];
    bpps[0] = 16'd8;  ws[0] = 32'd2;     hs[0] = 32'd2;          offs[0] = 32'd54; exps[0] = 2'd2;
    bpps[1] = 16'd24; ws[1] = 32'd0;     hs[1] = 32'd2;          offs[1] = 32'd54; exps[1] = 2'd3;
    bpps[2] = 16'd24; ws[2] = 32'd2;     hs[2] = 32'hFFFFFFFE;   offs[2] = 32'd54; exps[2] = 2'd3;
    bpps[3] = 16'd24; ws[3] = 32'd70000; hs[3] = 32'd2;          offs[3] = 32'd54; exps[3] = 2'd3;
    for (int c = 0; c < 4; c++) begin
      do_restart();
      build(8'h42, bpps[c], ws[c], hs[c], offs[c], 128'd0, 0);
      stream(0, 54);
      total++;
      if (err !== exps[c] || hdr_valid !== 1'b0) begin bad++; $display("FAIL hdr_case%0d: got err=%0d hv=%b want %0d 0", c, err, hdr_valid, exps[c]); end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pv;
    logic [57:0]  exp_px [3];
    int           st;
    exp_px[0] = {24'h131211, 16'd0, 16'd0, 1'b0, 1'b0};
    exp_px[1] = {24'h232221, 16'd1, 16'd0, 1'b0, 1'b0};
    exp_px[2] = {24'h333231, 16'd2, 16'd0, 1'b1, 1'b1};
    do_restart();
    bus.out_ready = 1'b0;
    pv = 128'h11121321222331323300000000000000;
    build(8'h42, 16'd24, 32'd3, 32'd1, 32'd54, pv, 12);
    st = pq.size();
    stream(0, 54);
    fork
      stream(54, 12);
      begin : hold_sink
        int          g, chg;
        logic [23:0] held;
        g = 0; chg = 0;
        @(negedge clk);
        while (!bus.out_valid && g < 200) begin @(negedge clk); g++; end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid: got %b want 1", bus.out_valid); end
        held = bus.out_data;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (bus.out_data !== held) chg++;
        end
        total++; if (chg != 0 || held !== 24'h131211) begin bad++; $display("FAIL bp_stable: got %h changes=%0d want 131211 changes=0", held, chg); end
        total++; if (bus.in_ready !== 1'b0 || bus.in_data !== 8'h23) begin bad++; $display("FAIL bp_in_ready: got rdy=%b byte=%h want 0 23", bus.in_ready, bus.in_data); end
        total++; if (pq.size() != st) begin bad++; $display("FAIL bp_no_handshake: got %0d want 0", pq.size() - st); end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    settle(4);
    total++; if (pq.size() - st != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", pq.size() - st); end
    for (int k = 0; k < 3; k++) begin
      if (st + k < pq.size()) begin
        total++;
        if (pq[st + k] !== exp_px[k]) begin bad++; $display("FAIL bp_pix%0d: got %h want %h", k, pq[st + k], exp_px[k]); end
      end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done: got %b want 1", done); end
  endtask

  task automatic test_restart_mid_pix();
    int st;
    do_restart();
    bus.out_ready = 1'b0;
    build(8'h42, 16'd24, 32'd2, 32'd2, 32'd54, 128'h01020304050600000708090A0B0C0000, 16);
    stream(0, 57);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rs_pending: got %b want 1", bus.out_valid); end
    restart = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h42;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rs_in_ready: got %b want 0", bus.in_ready); end
    @(posedge clk); #1;
    restart = 1'b0; bus.in_valid = 1'b0;
    total++; if ({bus.out_valid, hdr_valid, done, err} !== 5'b0) begin bad++; $display("FAIL rs_cleared: got %b want 00000", {bus.out_valid, hdr_valid, done, err}); end
    bus.out_ready = 1'b1;
    build(8'h42, 16'd24, 32'd1, 32'd1, 32'd54, 128'h44556600000000000000000000000000, 4);
    st = pq.size();
    stream(0, 58);
    settle(4);
    total++; if (pq.size() - st != 1) begin bad++; $display("FAIL rs_count: got %0d want 1", pq.size() - st); end
    if (pq.size() > st) begin
      total++;
      if (pq[st] !== {24'h665544, 16'd0, 16'd0, 1'b1, 1'b1}) begin bad++; $display("FAIL rs_pix: got %h want 665544 x0 y0 eol last", pq[st]); end
    end
    total++; if (done !== 1'b1 || err !== 2'd0) begin bad++; $display("FAIL rs_done: got done=%b err=%0d want 1 0", done, err); end
  endtask

  task automatic test_async_reset();
    do_restart();
    bus.out_ready = 1'b0;
    build(8'h42, 16'd24, 32'd2, 32'd2, 32'd54, 128'h01020304050600000708090A0B0C0000, 16);
    stream(0, 57);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.out_valid, hdr_valid, bmp_width} !== 34'd0) begin bad++; $display("FAIL ar_cleared: got ov=%b hv=%b w=%0d want 0", bus.out_valid, hdr_valid, bmp_width); end
    @(posedge clk); #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    settle(1);
  endtask

  initial begin
    test_reset();
    test_frame_2x2(54);
    test_frame_2x2(58);
    test_bad_signature();
    test_bad_header();
    test_backpressure();
    test_restart_mid_pix();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bmp_stream_parser.md
BMP_STREAM_PARSER -- requirements
Module: bmp_stream_parser

Interface
REQ-001 Parameters: none; all widths fixed below.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 restart  input  1  synchronous pulse; returns block to header parsing.
REQ-005 in_valid  input  1  file byte present on in_data.
REQ-006 in_data  input  8  BMP file byte, file order from offset 0.
REQ-007 in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-008 out_valid  output  1  pixel present.
REQ-009 out_ready  input  1  pixel consumed when out_valid && out_ready.
REQ-010 out_data  output  24  pixel as {R,G,B}.
REQ-011 out_x, out_y  output  16 each  column and file-row index of pixel (row 0 = first row in file).
REQ-012 out_eol, out_last  output  1 each  last pixel of row; last pixel of image.
REQ-013 hdr_valid  output  1  header fields below valid.
REQ-014 file_size, data_offset, bmp_width, bmp_height  output  32 each  little-endian fields from offsets 2, 10, 18, 22.
REQ-015 done, err  output  1, 2  image complete; error code (0 none, 1 signature, 2 bpp, 3 geometry).

Function
REQ-016 States: HDR, SKIP, PIX, PAD, DONE, ERR; 32-bit byte counter bcnt = accepted bytes since restart.
REQ-017 HDR: in_ready=1; fields captured byte-wise as accepted; bpp captured from offsets 28-29.
REQ-018 On acceptance of byte 53, checks in priority: bytes0-1 != 0x42,0x4D -> err=1; bpp != 24 -> err=2; width==0, width>65535, height==0, height[31]=1, or data_offset<54 -> err=3; any error -> ERR, else hdr_valid=1 next cycle.
REQ-019 Valid header: data_offset==54 -> PIX; else SKIP.
REQ-020 SKIP: in_ready=1; bytes discarded; on acceptance of byte at bcnt==data_offset-1 -> PIX.
REQ-021 PIX: bytes taken in B,G,R order; in_ready=1 for B,G; for R byte in_ready = !out_valid || out_ready.
REQ-022 Pixel register loads on R acceptance; out_valid high the following cycle (latency 1 from R byte); held with stable data until out_ready.
REQ-023 Concurrent out_ready handshake and new R load: register takes new pixel, out_valid stays high; no bubble, no loss.
REQ-024 Row padding bytes per row = bmp_width[1:0]; after last pixel of a row, PAD if padding>0, else next row.
REQ-025 PAD: in_ready=1; discards exactly bmp_width[1:0] bytes, then PIX.
REQ-026 x wraps to 0 and y increments at row end; out_eol=1 when out_x==width-1; out_last=1 when also out_y==height-1.
REQ-027 After final row's padding (or final pixel if no padding) -> DONE; done=1 once the last pixel handshakes.
REQ-028 DONE and ERR: in_ready=1, trailing bytes discarded; state, done, err, header outputs held.
REQ-029 restart: in any state, next cycle HDR, bcnt=0, out_valid=0, hdr_valid=0, done=0, err=0; an input byte in the restart cycle is discarded (in_ready=0 while restart high).
REQ-030 out_valid never depends combinationally on out_ready; in_ready may depend on out_ready.

Reset
REQ-031 rst_n low: state HDR, bcnt=0, all outputs 0 except in_ready=1 after release; header fields 0.
REQ-032 Reset mid-image discards partial pixel and pending output pixel without handshake.

Verification
REQ-033 2x2 image, offset 54, bytes 54..69 = 01 02 03 04 05 06 00 00 07 08 09 0A 0B 0C 00 00, out_ready=1 -> pixels 030201(0,0), 060504(1,0,eol), 090807(0,1), 0C0B0A(1,1,eol,last); done=1; hdr_valid, width=2, height=2.
REQ-034 Same file with data_offset=58 and 4 gap bytes -> gap skipped, identical pixel output.
REQ-035 Byte 0 = 0x41 -> err=1 after byte 53, no out_valid ever, in_ready stays 1.
REQ-036 bpp=8 -> err=2; width=0 -> err=3; height=0xFFFFFFFE -> err=3.
REQ-037 3x1 image (pad 3), out_ready held low 10 cycles after first pixel -> in_ready drops on 2nd pixel's R byte, out_data stable, all 3 pixels delivered in order after release.
REQ-038 restart asserted mid-PIX then valid 1x1 file streamed -> only new pixel emitted, out_last=1, done=1.
